serial_word_feeder: RTL and testbench
=====================================

// Module: serial_word_feeder
// PURPOSE
//  Parallel-to-serial stage directly upstream of the 1011 sequence detector.
//  Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock, MSB first.
//  sequence_out drives the detector's serial input.
//  A one-word holding buffer lets consecutive words stream with no idle gap.
// PARAMETERS
//  WIDTH       8   bits per word (>=2)
//  IDLE_LEVEL  0   value driven on sequence_out when no bit is valid
// PORTS
//  clock         in   1      single clock; all state updates on posedge
//  reset         in   1      synchronous, active-high
//  data_in       in   WIDTH  parallel word, MSB transmitted first
//  data_valid    in   1      data_in holds a word
//  data_ready    out  1      block can take a word this cycle
//  sequence_out  out  1      serial bit to detector
//  bit_valid     out  1      sequence_out carries a word bit this cycle
//  word_done     out  1      high in the cycle the last bit (LSB) of a word is presented
//  busy          out  1      shifting, or holding buffer occupied
// BEHAVIOUR
//  Reset: sync, active-high; takes effect at the next posedge.
//   - state=IDLE, hold_full=0, shift_reg=0, bit_cnt=0.
//   - While reset=1: data_ready=0, sequence_out=IDLE_LEVEL, bit_valid=0, word_done=0, busy=0.
//   - Reset mid-word discards the word in flight and the held word; no partial bits after reset.
//  Handshake:
//   - Transfer on the posedge where data_valid & data_ready.
//   - data_ready = !hold_full & !reset, from registers only; no combinational path from data_valid.
//   - data_in is ignored when no transfer occurs.
//  FSM states: IDLE, SHIFT.
//   IDLE:
//    - A transfer loads shift_reg, bit_cnt=0, next state SHIFT.
//    - First bit appears in the cycle after the transfer edge (1-cycle latency).
//   SHIFT:
//    - sequence_out = shift_reg[WIDTH-1], bit_valid=1.
//    - Each edge: shift left by 1, bit_cnt+1.
//    - Last bit is bit_cnt==WIDTH-1; word_done=1 in that cycle.
//   Last bit, hold_full=1: load hold into shift_reg, clear hold_full, stay SHIFT (gapless).
//   Last bit, hold empty, transfer this cycle: bypass data_in straight into shift_reg, stay SHIFT (gapless).
//   Last bit, hold empty, no transfer: go to IDLE. Next cycle bit_valid=0, sequence_out=IDLE_LEVEL.
//   Not last bit, hold empty, transfer: write hold, hold_full=1.
//  bit_cnt width: $clog2(WIDTH); it wraps to 0 on every word load.
//  busy = (state==SHIFT) | hold_full.
//  Outputs are decoded from registered state only (Moore style), matching the detector's Moore stage.
//  Gaps are real zeros (IDLE_LEVEL) to the detector.
// STRUCTURE
//  Package seq_pkg:
//   - feeder_state_t {IDLE=1'b0, SHIFT=1'b1}
//   - FEED_WIDTH_DEF = 8
//  One sub-module is natural: feeder_hold_buf, a 1-entry register with full flag and write/read strobes.
//  Shift register, counter and FSM stay in this module.
// TESTING (WIDTH=8, IDLE_LEVEL=0; cycle 0 = transfer edge)
//  1. Single word 8'hB0:
//     - sequence_out = 1,0,1,1,0,0,0,0 in cycles 1-8.
//     - bit_valid=1 in cycles 1-8; word_done=1 only in cycle 8; cycle 9 bit_valid=0.
//  2. Back-to-back 8'hB0 then 8'h2D, second offered in cycle 2:
//     - held; 16 contiguous valid bits.
//     - data_ready=0 from cycle 3 until the hold drains at the cycle-8 edge.
//  3. Bypass: hold empty, 8'hFF offered exactly in the cycle word_done=1:
//     - accepted; first bit 1 in the next cycle.
//     - no bit_valid gap; hold_full stays 0.
//  4. data_valid held high with data_ready=0 (hold full):
//     - no transfer; held word and data_in changes do not corrupt the stream.
//  5. Reset asserted in cycle 4 of a word, with hold full:
//     - next cycle all outputs at reset values.
//     - After release: data_ready=1, no stale bits; a new word 8'h0B streams correctly.
//  6. End to end with the detector, words 8'hB0,8'hB0:
//     - detector output pulses once per 1011 occurrence.
//     - Matches a reference model of the concatenated bitstream, including zero-filled gaps.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial word feeder that drives the 1011 detector.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } feeder_state_t;

    localparam int FEED_WIDTH_DEF = 8;

endpackage

// File: rtl/feeder_hold_buf.sv
// One-entry holding register with a full flag. A write sets full and a read clears it.
// A write takes priority if both strobes arrive in the same cycle.
module feeder_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    logic [WIDTH-1:0] data_q;

    // Capture the word on write; track occupancy from the write/read strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
            full   <= 1'b0;
        end else begin
            if (wr_en) begin
                data_q <= wr_data;
            end
            if (wr_en) begin
                full <= 1'b1;
            end else if (rd_en) begin
                full <= 1'b0;
            end
        end
    end

    assign rd_data = data_q;

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder, MSB first, with a one-word holding buffer so that
// consecutive words leave with no idle gap between them.
//
//   state | meaning
//   IDLE  | no word in flight; sequence_out sits at IDLE_LEVEL
//   SHIFT | presenting shift_reg MSB; bit_cnt counts bits already sent
module serial_word_feeder
    import seq_pkg::*;
#(
    parameter int WIDTH      = FEED_WIDTH_DEF,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             sequence_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    feeder_state_t    state;
    feeder_state_t    state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;

    logic             transfer;
    logic             last_bit;
    logic             load_in;
    logic             load_hold;
    logic             shift_en;
    logic             hold_wr;
    logic             hold_rd;

    feeder_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (hold_wr),
        .wr_data (data_in),
        .rd_en   (hold_rd),
        .rd_data (hold_data),
        .full    (hold_full)
    );

    // Ready depends only on the hold flag and reset, never on data_valid.
    assign data_ready = !hold_full && !reset;
    assign transfer   = data_valid && data_ready;
    assign last_bit   = (bit_cnt == CNT_W'(WIDTH - 1));
    assign load_hold  = hold_rd;

    // Next-state and datapath strobes; the last bit decides between refill and idling.
    always_comb begin
        state_next = state;
        load_in    = 1'b0;
        shift_en   = 1'b0;
        hold_wr    = 1'b0;
        hold_rd    = 1'b0;
        case (state)
            IDLE: begin
                if (transfer) begin
                    load_in    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (hold_full) begin
                        hold_rd = 1'b1;
                    end else if (transfer) begin
                        load_in = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    shift_en = 1'b1;
                    if (transfer) begin
                        hold_wr = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, shift register and bit counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state <= state_next;
            if (load_in) begin
                shift_reg <= data_in;
                bit_cnt   <= '0;
            end else if (load_hold) begin
                shift_reg <= hold_data;
                bit_cnt   <= '0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                bit_cnt   <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Moore outputs from registered state, forced quiet while reset is high.
    assign bit_valid    = (state == SHIFT) && !reset;
    assign sequence_out = bit_valid ? shift_reg[WIDTH-1] : IDLE_LEVEL;
    assign word_done    = bit_valid && last_bit;
    assign busy         = ((state == SHIFT) || hold_full) && !reset;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder (WIDTH=8, IDLE_LEVEL=0): a hand-written vector table,
// directed multi-cycle sequences and random traffic against a bit-queue reference model.
module tb_serial_word_feeder;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic [W-1:0] data_in;
    logic         data_valid;
    logic         data_ready;
    logic         sequence_out;
    logic         bit_valid;
    logic         word_done;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    serial_word_feeder #(
        .WIDTH      (W),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .sequence_out (sequence_out),
        .bit_valid    (bit_valid),
        .word_done    (word_done),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         seq;
        logic         bv;
        logic         wd;
        logic         rdy;
        logic         bsy;
    } vec_t;

    // Reference model: every accepted word appends its bits (MSB first) to a queue;
    // one bit leaves per clock. More than W queued bits means the hold is occupied.
    bit q[$];
    bit cap[$];
    bit capture_on = 1'b0;

    task automatic chk(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0b exp=%0b t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic int count_1011(input bit s[$]);
        int n = 0;
        for (int i = 0; i + 3 < s.size(); i++)
            if (s[i] && !s[i+1] && s[i+2] && s[i+3]) n++;
        return n;
    endfunction

    task automatic push_word(inout bit s[$], input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) s.push_back(d[i]);
    endtask

    task automatic apply(input logic v, input logic [W-1:0] d, input logic r,
                         input string tag, input bit use_tbl, input vec_t e);
        logic m_seq, m_bv, m_wd, m_rdy, m_bsy;
        data_valid = v;
        data_in    = d;
        reset      = r;
        @(negedge clock);
        if (r) begin
            m_seq = 1'b0; m_bv = 1'b0; m_wd = 1'b0; m_rdy = 1'b0; m_bsy = 1'b0;
        end else begin
            m_bv  = (q.size() > 0);
            m_seq = m_bv ? q[0] : 1'b0;
            m_wd  = (q.size() % W) == 1;
            m_rdy = (q.size() <= W);
            m_bsy = m_bv;
        end
        if (use_tbl) begin
            m_seq = e.seq; m_bv = e.bv; m_wd = e.wd; m_rdy = e.rdy; m_bsy = e.bsy;
        end
        chk({tag, ".sequence_out"}, sequence_out, m_seq);
        chk({tag, ".bit_valid"},    bit_valid,    m_bv);
        chk({tag, ".word_done"},    word_done,    m_wd);
        chk({tag, ".data_ready"},   data_ready,   m_rdy);
        chk({tag, ".busy"},         busy,         m_bsy);
        if (capture_on) cap.push_back(sequence_out);
        @(posedge clock);
        if (r) begin
            q.delete();
        end else begin
            logic xfer;
            xfer = v && (q.size() <= W);
            if (q.size() > 0) void'(q.pop_front());
            if (xfer) push_word(q, d);
        end
        #1;
    endtask

    vec_t tbl[$];
    vec_t none;

    initial begin
        bit ref_s[$];
        data_valid = 1'b0;
        data_in    = '0;
        reset      = 1'b1;
        none       = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        #1;

        // Reset, then a single 8'hB0: bits 1,0,1,1,0,0,0,0, word_done on the 8th, then idle.
        //            v     d      r     seq   bv    wd    rdy   bsy
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i].v, tbl[i].d, tbl[i].r, $sformatf("tbl%0d", i), 1'b1, tbl[i]);

        // Back-to-back: 8'h2D offered in cycle 2 is held, 16 contiguous bits follow.
        apply(1'b1, 8'hB0, 1'b0, "b2b", 1'b0, none);
        apply(1'b0, 8'h00, 1'b0, "b2b", 1'b0, none);
        apply(1'b1, 8'h2D, 1'b0, "b2b", 1'b0, none);
        for (int i = 0; i < 16; i++) apply(1'b0, 8'h00, 1'b0, "b2b", 1'b0, none);

        // Bypass: 8'hFF offered exactly in the word_done cycle of 8'hB0.
        apply(1'b1, 8'hB0, 1'b0, "byp", 1'b0, none);
        for (int i = 1; i <= 7; i++) apply(1'b0, 8'h00, 1'b0, "byp", 1'b0, none);
        apply(1'b1, 8'hFF, 1'b0, "byp", 1'b0, none);
        for (int i = 0; i < 10; i++) apply(1'b0, 8'h00, 1'b0, "byp", 1'b0, none);

        // data_valid stuck high while the hold is full, with data_in wandering.
        apply(1'b1, 8'hB0, 1'b0, "stall", 1'b0, none);
        apply(1'b0, 8'h00, 1'b0, "stall", 1'b0, none);
        apply(1'b1, 8'h2D, 1'b0, "stall", 1'b0, none);
        for (int i = 0; i < 8; i++)
            apply(1'b1, 8'($urandom), 1'b0, "stall", 1'b0, none);
        for (int i = 0; i < 20; i++) apply(1'b0, 8'h00, 1'b0, "stall", 1'b0, none);

        // Reset in cycle 4 of a word with the hold full, then a clean 8'h0B.
        apply(1'b1, 8'hB0, 1'b0, "rst", 1'b0, none);
        apply(1'b0, 8'h00, 1'b0, "rst", 1'b0, none);
        apply(1'b1, 8'hC3, 1'b0, "rst", 1'b0, none);
        apply(1'b0, 8'h00, 1'b0, "rst", 1'b0, none);
        apply(1'b0, 8'h00, 1'b1, "rst", 1'b0, none);
        apply(1'b0, 8'h00, 1'b0, "rst", 1'b0, none);
        apply(1'b1, 8'h0B, 1'b0, "rst", 1'b0, none);
        for (int i = 0; i < 10; i++) apply(1'b0, 8'h00, 1'b0, "rst", 1'b0, none);

        // End to end: serial stream of B0, gap, B0 against the concatenated reference.
        capture_on = 1'b1;
        apply(1'b1, 8'hB0, 1'b0, "e2e", 1'b0, none);
        for (int i = 0; i < 9; i++) apply(1'b0, 8'h00, 1'b0, "e2e", 1'b0, none);
        apply(1'b1, 8'hB0, 1'b0, "e2e", 1'b0, none);
        for (int i = 0; i < 9; i++) apply(1'b0, 8'h00, 1'b0, "e2e", 1'b0, none);
        capture_on = 1'b0;
        ref_s.push_back(1'b0);
        push_word(ref_s, 8'hB0);
        ref_s.push_back(1'b0);
        ref_s.push_back(1'b0);
        push_word(ref_s, 8'hB0);
        ref_s.push_back(1'b0);
        n_tests++;
        if (cap != ref_s) begin
            n_fail++;
            $display("FAIL e2e.stream got_len=%0d exp_len=%0d", cap.size(), ref_s.size());
        end
        n_tests++;
        if (count_1011(cap) != count_1011(ref_s)) begin
            n_fail++;
            $display("FAIL e2e.detect got=%0d exp=%0d", count_1011(cap), count_1011(ref_s));
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++)
            apply(($urandom_range(0, 1) == 1), 8'($urandom),
                  ($urandom_range(0, 63) == 0), "rnd", 1'b0, none);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
